// File: rtl/ysyx_lsu_sq.sv
// Committed store queue: buffers retired stores, drains them in order to the data-memory
// write port and optionally forwards to younger loads (enabled by YSYX_SQ_FORWARD_EN).
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_lsu_sq #(
  parameter int SQ_SIZE = 4,
  parameter int XLEN    = `YSYX_XLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rou_valid,
  input  logic            rou_store,
  input  logic [4:0]      rou_alu,
  input  logic [XLEN-1:0] rou_sq_waddr,
  input  logic [XLEN-1:0] rou_sq_wdata,
  input  logic [XLEN-1:0] rou_pc,
  output logic            rou_sq_ready,
  output logic            mem_wvalid,
  output logic [XLEN-1:0] mem_waddr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wpc,
  input  logic            mem_wready,
  input  logic            mem_bvalid,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [4:0]      ld_alu,
  input  logic            ld_valid,
  output logic            ld_hit,
  output logic [XLEN-1:0] ld_data,
  output logic            ld_conflict,
  output logic            sq_empty
);

  localparam int PW   = $clog2(SQ_SIZE);
  localparam int PTRW = PW + 1;
  localparam logic [PTRW-1:0] PTR_ONE = PTRW'(1);

  // state  | meaning
  // S_IDLE | no write in flight; start one if the queue holds an entry
  // S_REQ  | head entry presented on mem_w*, waiting for mem_wready
  // S_WAIT | write accepted, waiting for mem_bvalid to pop the head
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PTRW-1:0] r_head;
  logic [PTRW-1:0] r_tail;
  logic [XLEN-1:0] r_addr [SQ_SIZE];
  logic [XLEN-1:0] r_data [SQ_SIZE];
  logic [XLEN-1:0] r_pc   [SQ_SIZE];
  logic [3:0]      r_strb [SQ_SIZE];

  logic            w_full;
  logic            w_empty;
  logic            w_enq;
  logic            w_pop;
  logic [PTRW-1:0] w_count;
  logic [PW-1:0]   w_hidx;
  logic [1:0]      w_enq_off;
  logic [3:0]      w_enq_strb;
  logic [XLEN-1:0] w_enq_data;
  logic [XLEN-1:0] w_ld_waddr;
  logic [PW-1:0]   w_idx;
  logic            w_word_any;

  assign w_empty = (r_head == r_tail);
  assign w_full  = (r_head[PW] != r_tail[PW]) && (r_head[PW-1:0] == r_tail[PW-1:0]);
  assign w_count = r_tail - r_head;
  assign w_hidx  = r_head[PW-1:0];
  assign w_enq   = rou_valid && rou_store && !w_full;
  assign w_pop   = (r_state == S_WAIT) && mem_bvalid;

  always_comb begin
    w_enq_off  = 2'b00;
    w_enq_strb = 4'b1111;
    case (rou_alu[1:0])
      2'b00: begin
        w_enq_off  = rou_sq_waddr[1:0];
        w_enq_strb = 4'b0001 << w_enq_off;
      end
      2'b01: begin
        w_enq_off  = {rou_sq_waddr[1], 1'b0};
        w_enq_strb = 4'b0011 << w_enq_off;
      end
      default: ;
    endcase
    w_enq_data = rou_sq_wdata << {w_enq_off, 3'b000};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_enq) r_tail <= r_tail + PTR_ONE;
      if (w_pop) r_head <= r_head + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_addr[r_tail[PW-1:0]] <= {rou_sq_waddr[XLEN-1:2], 2'b00};
      r_data[r_tail[PW-1:0]] <= w_enq_data;
      r_strb[r_tail[PW-1:0]] <= w_enq_strb;
      r_pc[r_tail[PW-1:0]]   <= rou_pc;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty)   w_state_nxt = S_REQ;
      S_REQ:   if (mem_wready) w_state_nxt = S_WAIT;
      S_WAIT:  if (mem_bvalid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are forced to zero outside REQ so idle/reset values do not depend on stale storage.
  assign mem_wvalid   = (r_state == S_REQ);
  assign mem_waddr    = mem_wvalid ? r_addr[w_hidx] : '0;
  assign mem_wdata    = mem_wvalid ? r_data[w_hidx] : '0;
  assign mem_wstrb    = mem_wvalid ? r_strb[w_hidx] : 4'b0000;
  assign mem_wpc      = mem_wvalid ? r_pc[w_hidx]   : '0;
  assign rou_sq_ready = !w_full;
  assign sq_empty     = w_empty && (r_state == S_IDLE);

  assign w_ld_waddr = {ld_addr[XLEN-1:2], 2'b00};

  always_comb begin
    w_word_any = 1'b0;
    w_idx      = w_hidx;
    for (int k = 0; k < SQ_SIZE; k++) begin
      w_idx = w_hidx + PW'(k);
      if ((PTRW'(k) < w_count) && (r_addr[w_idx] == w_ld_waddr)) w_word_any = 1'b1;
    end
  end

`ifdef YSYX_SQ_FORWARD_EN
  logic [1:0]      w_ld_off;
  logic [3:0]      w_ld_strb;
  logic [XLEN-1:0] w_ld_mask;
  logic            w_hit_any;
  logic            w_cover;
  logic [3:0]      w_sel_strb;
  logic [XLEN-1:0] w_sel_data;
  logic [PW-1:0]   w_fidx;
  logic            w_unused;

  always_comb begin
    w_ld_off  = 2'b00;
    w_ld_strb = 4'b1111;
    w_ld_mask = '1;
    case (ld_alu[1:0])
      2'b00: begin
        w_ld_off  = ld_addr[1:0];
        w_ld_strb = 4'b0001 << w_ld_off;
        w_ld_mask = {{(XLEN-8){1'b0}}, 8'hFF};
      end
      2'b01: begin
        w_ld_off  = {ld_addr[1], 1'b0};
        w_ld_strb = 4'b0011 << w_ld_off;
        w_ld_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
      end
      default: ;
    endcase
  end

  // Walk oldest to youngest so the last overlapping entry seen is the youngest.
  always_comb begin
    w_hit_any  = 1'b0;
    w_sel_strb = 4'b0000;
    w_sel_data = '0;
    w_fidx     = w_hidx;
    for (int k = 0; k < SQ_SIZE; k++) begin
      w_fidx = w_hidx + PW'(k);
      if ((PTRW'(k) < w_count) && (r_addr[w_fidx] == w_ld_waddr) &&
          ((r_strb[w_fidx] & w_ld_strb) != 4'b0000)) begin
        w_hit_any  = 1'b1;
        w_sel_strb = r_strb[w_fidx];
        w_sel_data = r_data[w_fidx];
      end
    end
  end

  assign w_cover     = ((w_sel_strb & w_ld_strb) == w_ld_strb);
  assign ld_hit      = ld_valid && w_hit_any && w_cover;
  assign ld_conflict = ld_valid && w_hit_any && !w_cover;
  assign ld_data     = ld_hit ? ((w_sel_data >> {w_ld_off, 3'b000}) & w_ld_mask) : '0;
  assign w_unused    = ^{rou_alu[4:2], ld_alu[4:2], w_word_any};
`else
  logic w_unused;

  assign ld_hit      = 1'b0;
  assign ld_data     = '0;
  assign ld_conflict = ld_valid && w_word_any;
  assign w_unused    = ^{rou_alu[4:2], ld_alu, ld_addr[1:0]};
`endif

endmodule

// File: tb/tb_ysyx_lsu_sq.sv
// Self-checking bench for ysyx_lsu_sq: directed scenarios plus randomized traffic against a
// queue-based reference model. Forwarding expectations follow YSYX_SQ_FORWARD_EN.
module tb_ysyx_lsu_sq;
  localparam int SQ = 4;
`ifdef YSYX_SQ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        rou_valid, rou_store, rou_sq_ready;
  logic [4:0]  rou_alu;
  logic [31:0] rou_sq_waddr, rou_sq_wdata, rou_pc;
  logic        mem_wvalid, mem_wready, mem_bvalid;
  logic [31:0] mem_waddr, mem_wdata, mem_wpc;
  logic [3:0]  mem_wstrb;
  logic [31:0] ld_addr, ld_data;
  logic [4:0]  ld_alu;
  logic        ld_valid, ld_hit, ld_conflict, sq_empty;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] pc;
  } ent_t;
  ent_t mq[$];

  always #5 clock = ~clock;

  ysyx_lsu_sq #(.SQ_SIZE(SQ), .XLEN(32)) dut (
    .clock(clock), .reset(reset),
    .rou_valid(rou_valid), .rou_store(rou_store), .rou_alu(rou_alu),
    .rou_sq_waddr(rou_sq_waddr), .rou_sq_wdata(rou_sq_wdata), .rou_pc(rou_pc),
    .rou_sq_ready(rou_sq_ready),
    .mem_wvalid(mem_wvalid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_wpc(mem_wpc), .mem_wready(mem_wready), .mem_bvalid(mem_bvalid),
    .ld_addr(ld_addr), .ld_alu(ld_alu), .ld_valid(ld_valid), .ld_hit(ld_hit),
    .ld_data(ld_data), .ld_conflict(ld_conflict), .sq_empty(sq_empty)
  );

  function automatic int lane_off(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd0) return int'(a[1:0]);
    if (sz == 2'd1) return a[1] ? 2 : 0;
    return 0;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] s);
    logic [31:0] m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic ent_t mk_ent(input logic [31:0] a, d, pc, input logic [1:0] sz);
    ent_t e;
    int off = lane_off(a, sz);
    e.waddr = {a[31:2], 2'b00};
    e.strb  = 4'(((1 << nbytes(sz)) - 1) << off);
    e.wdata = d << (8 * off);
    e.pc    = pc;
    return e;
  endfunction

  // Reference lookup: youngest store touching the load's bytes decides hit or retry.
  task automatic model_lookup(input logic v, input logic [31:0] a, input logic [1:0] sz,
                              output logic hit, output logic conf, output logic [31:0] data);
    int off = lane_off(a, sz);
    int nb = nbytes(sz);
    int sel = -1;
    logic [3:0] ls = 4'(((1 << nb) - 1) << off);
    hit = 1'b0; conf = 1'b0; data = '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (sel < 0 && mq[i].waddr == {a[31:2], 2'b00} && (!FWD || (mq[i].strb & ls) != 4'b0))
        sel = i;
    if (v && sel >= 0) begin
      if (FWD && (mq[sel].strb & ls) == ls) begin
        hit = 1'b1;
        for (int b = 0; b < nb; b++) data[8*b +: 8] = mq[sel].wdata[8*(off+b) +: 8];
      end else conf = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    rou_valid = 0; rou_store = 0; rou_alu = '0; rou_sq_waddr = '0; rou_sq_wdata = '0; rou_pc = '0;
    mem_wready = 0; mem_bvalid = 0; ld_addr = '0; ld_alu = '0; ld_valid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    mq.delete();
  endtask

  task automatic drive_store(input logic [31:0] a, d, pc, input logic [1:0] sz);
    rou_valid = 1; rou_store = 1; rou_alu = {3'b000, sz};
    rou_sq_waddr = a; rou_sq_wdata = d; rou_pc = pc;
  endtask

  task automatic commit(input logic [31:0] a, d, pc, input logic [1:0] sz);
    drive_store(a, d, pc, sz);
    step();
    rou_valid = 0; rou_store = 0;
  endtask

  task automatic test_reset();
    do_reset();
    ld_valid = 1; ld_addr = 32'h100; ld_alu = 5'd2;
    #1;
    n_tests++;
    if (sq_empty !== 1'b1 || rou_sq_ready !== 1'b1 || mem_wvalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: empty=%b ready=%b wvalid=%b want 1 1 0", sq_empty, rou_sq_ready, mem_wvalid);
    end
    n_tests++;
    if (mem_waddr !== 0 || mem_wdata !== 0 || mem_wstrb !== 0 || mem_wpc !== 0) begin
      n_fail++; $display("FAIL reset_mem: addr=%h data=%h strb=%b pc=%h want zeros", mem_waddr, mem_wdata, mem_wstrb, mem_wpc);
    end
    n_tests++;
    if (ld_hit !== 1'b0 || ld_conflict !== 1'b0 || ld_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_ld: hit=%b conf=%b data=%h want 0 0 0", ld_hit, ld_conflict, ld_data);
    end
    idle_inputs();
  endtask

  task automatic test_basic_drain();
    do_reset();
    mem_wready = 1;
    commit(32'h8000_0004, 32'hDEAD_BEEF, 32'h8000_0100, 2'd2);
    n_tests++;
    if (mem_wvalid !== 1'b0 || sq_empty !== 1'b0) begin
      n_fail++; $display("FAIL basic_n1: wvalid=%b empty=%b want 0 0", mem_wvalid, sq_empty);
    end
    step();
    n_tests++;
    if (mem_wvalid !== 1'b1 || mem_waddr !== 32'h8000_0004 || mem_wstrb !== 4'b1111) begin
      n_fail++; $display("FAIL basic_req: wvalid=%b addr=%h strb=%b want 1 80000004 1111", mem_wvalid, mem_waddr, mem_wstrb);
    end
    n_tests++;
    if (mem_wdata !== 32'hDEAD_BEEF || mem_wpc !== 32'h8000_0100) begin
      n_fail++; $display("FAIL basic_data: data=%h pc=%h want deadbeef 80000100", mem_wdata, mem_wpc);
    end
    step();
    mem_wready = 0;
    n_tests++;
    if (mem_wvalid !== 1'b0 || sq_empty !== 1'b0) begin
      n_fail++; $display("FAIL basic_wait: wvalid=%b empty=%b want 0 0", mem_wvalid, sq_empty);
    end
    step(); step();
    mem_bvalid = 1;
    step();
    mem_bvalid = 0;
    n_tests++;
    if (sq_empty !== 1'b1) begin
      n_fail++; $display("FAIL basic_empty: empty=%b want 1", sq_empty);
    end
  endtask

  task automatic test_byte_lane();
    do_reset();
    commit(32'h8000_0003, 32'h0000_00AB, 32'h10, 2'd0);
    step();
    n_tests++;
    if (mem_wdata !== 32'hAB00_0000 || mem_wstrb !== 4'b1000 || mem_waddr !== 32'h8000_0000) begin
      n_fail++; $display("FAIL byte_lane: data=%h strb=%b addr=%h want ab000000 1000 80000000", mem_wdata, mem_wstrb, mem_waddr);
    end
    do_reset();
    commit(32'h8000_0007, 32'h0000_1234, 32'h14, 2'd1);
    step();
    n_tests++;
    if (mem_wdata !== 32'h1234_0000 || mem_wstrb !== 4'b1100 || mem_waddr !== 32'h8000_0004) begin
      n_fail++; $display("FAIL half_lane: data=%h strb=%b addr=%h want 12340000 1100 80000004", mem_wdata, mem_wstrb, mem_waddr);
    end
  endtask

  task automatic test_full_wrap();
    logic [31:0] dat [10];
    int next = 4, drained = 0, phase = 0;
    logic acc, popnow;
    do_reset();
    for (int i = 0; i < 10; i++) dat[i] = $urandom;
    for (int i = 0; i < 5; i++) begin
      drive_store(32'h200 + 32'(4*i), dat[i], 32'(i), 2'd2);
      n_tests++;
      if (rou_sq_ready !== (i < SQ)) begin
        n_fail++; $display("FAIL full_ready%0d: ready=%b want %b", i, rou_sq_ready, (i < SQ));
      end
      if (i < SQ) mq.push_back(mk_ent(32'h200 + 32'(4*i), dat[i], 32'(i), 2'd2));
      step();
    end
    for (int cyc = 0; cyc < 200 && drained < 10; cyc++) begin
      idle_inputs();
      if (next < 10) drive_store(32'h200 + 32'(4*next), dat[next], 32'(next), 2'd2);
      acc = (next < 10) && (mq.size() < SQ);
      popnow = 1'b0;
      if (phase == 2) begin mem_bvalid = 1; popnow = 1'b1; end
      else if (mem_wvalid) begin
        n_tests++;
        if (mq.size() == 0 || mem_waddr !== mq[0].waddr || mem_wdata !== mq[0].wdata || mem_wpc !== mq[0].pc) begin
          n_fail++; $display("FAIL wrap_order: addr=%h data=%h pc=%h", mem_waddr, mem_wdata, mem_wpc);
        end
        mem_wready = 1;
      end
      n_tests++;
      if (rou_sq_ready !== (mq.size() < SQ)) begin
        n_fail++; $display("FAIL wrap_ready: ready=%b want %b", rou_sq_ready, (mq.size() < SQ));
      end
      step();
      if (acc) begin mq.push_back(mk_ent(32'h200 + 32'(4*next), dat[next], 32'(next), 2'd2)); next++; end
      if (popnow) begin void'(mq.pop_front()); drained++; phase = 0; end
      else if (mem_wready) phase = 2;
    end
    idle_inputs();
    n_tests++;
    if (drained != 10 || sq_empty !== 1'b1) begin
      n_fail++; $display("FAIL wrap_done: drained=%0d empty=%b want 10 1", drained, sq_empty);
    end
  endtask

  task automatic test_forward();
    do_reset();
    commit(32'h100, 32'h1122_3344, 32'h40, 2'd2);
    commit(32'h102, 32'h0000_AAAA, 32'h44, 2'd1);
    ld_valid = 1; ld_addr = 32'h100; ld_alu = 5'd2;
    #1;
    n_tests++;
    if (ld_hit !== 1'b0 || ld_conflict !== 1'b1) begin
      n_fail++; $display("FAIL fwd_lw100: hit=%b conf=%b want 0 1", ld_hit, ld_conflict);
    end
    ld_addr = 32'h102; ld_alu = 5'd1;
    #1;
    n_tests++;
    if (ld_hit !== FWD || ld_conflict !== !FWD || ld_data !== (FWD ? 32'h0000_AAAA : 32'h0)) begin
      n_fail++; $display("FAIL fwd_lh102: hit=%b conf=%b data=%h want %b %b", ld_hit, ld_conflict, ld_data, FWD, !FWD);
    end
    ld_addr = 32'h101; ld_alu = 5'd0;
    #1;
    n_tests++;
    if (ld_hit !== FWD || ld_conflict !== !FWD || ld_data !== (FWD ? 32'h33 : 32'h0)) begin
      n_fail++; $display("FAIL fwd_lb101: hit=%b conf=%b data=%h want %b %b", ld_hit, ld_conflict, ld_data, FWD, !FWD);
    end
    ld_addr = 32'h104; ld_alu = 5'd0;
    #1;
    n_tests++;
    if (ld_hit !== 1'b0 || ld_conflict !== 1'b0 || ld_data !== 32'h0) begin
      n_fail++; $display("FAIL fwd_miss: hit=%b conf=%b data=%h want 0 0 0", ld_hit, ld_conflict, ld_data);
    end
    ld_valid = 0; ld_addr = 32'h100; ld_alu = 5'd2;
    #1;
    n_tests++;
    if (ld_hit !== 1'b0 || ld_conflict !== 1'b0 || ld_data !== 32'h0) begin
      n_fail++; $display("FAIL fwd_novalid: hit=%b conf=%b data=%h want 0 0 0", ld_hit, ld_conflict, ld_data);
    end
    drive_store(32'h108, 32'h5566_7788, 32'h48, 2'd2);
    ld_valid = 1; ld_addr = 32'h108; ld_alu = 5'd2;
    #1;
    n_tests++;
    if (ld_hit !== 1'b0 || ld_conflict !== 1'b0) begin
      n_fail++; $display("FAIL fwd_samecyc: hit=%b conf=%b want 0 0", ld_hit, ld_conflict);
    end
    step();
    rou_valid = 0; rou_store = 0;
    #1;
    n_tests++;
    if (ld_hit !== FWD || ld_conflict !== !FWD || ld_data !== (FWD ? 32'h5566_7788 : 32'h0)) begin
      n_fail++; $display("FAIL fwd_nextcyc: hit=%b conf=%b data=%h want %b %b", ld_hit, ld_conflict, ld_data, FWD, !FWD);
    end
    idle_inputs();
  endtask

  task automatic test_hold_stall();
    do_reset();
    commit(32'h300, 32'hCAFE_F00D, 32'h1234, 2'd2);
    step();
    for (int k = 0; k < 5; k++) begin
      mem_bvalid = (k == 2);
      #1;
      n_tests++;
      if (mem_wvalid !== 1'b1 || mem_waddr !== 32'h300 || mem_wdata !== 32'hCAFE_F00D ||
          mem_wstrb !== 4'b1111 || mem_wpc !== 32'h1234 || sq_empty !== 1'b0) begin
        n_fail++; $display("FAIL hold_%0d: v=%b a=%h d=%h s=%b pc=%h e=%b", k, mem_wvalid, mem_waddr, mem_wdata, mem_wstrb, mem_wpc, sq_empty);
      end
      step();
    end
    mem_bvalid = 0; mem_wready = 1;
    step();
    mem_wready = 0;
    n_tests++;
    if (mem_wvalid !== 1'b0 || sq_empty !== 1'b0) begin
      n_fail++; $display("FAIL hold_wait: wvalid=%b empty=%b want 0 0", mem_wvalid, sq_empty);
    end
    mem_bvalid = 1;
    step();
    mem_bvalid = 0;
    n_tests++;
    if (sq_empty !== 1'b1) begin
      n_fail++; $display("FAIL hold_pop: empty=%b want 1", sq_empty);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    commit(32'h400, 32'h1, 32'h0, 2'd2);
    commit(32'h404, 32'h2, 32'h4, 2'd2);
    commit(32'h408, 32'h3, 32'h8, 2'd2);
    n_tests++;
    if (mem_wvalid !== 1'b1 || mem_waddr !== 32'h400) begin
      n_fail++; $display("FAIL mid_req: wvalid=%b addr=%h want 1 400", mem_wvalid, mem_waddr);
    end
    mem_wready = 1;
    step();
    mem_wready = 0;
    reset = 1;
    step();
    reset = 0;
    n_tests++;
    if (sq_empty !== 1'b1 || mem_wvalid !== 1'b0 || rou_sq_ready !== 1'b1 || mem_waddr !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset: empty=%b wvalid=%b ready=%b addr=%h want 1 0 1 0", sq_empty, mem_wvalid, rou_sq_ready, mem_waddr);
    end
    mem_bvalid = 1;
    step();
    mem_bvalid = 0;
    step();
    ld_valid = 1; ld_addr = 32'h404; ld_alu = 5'd2;
    #1;
    n_tests++;
    if (sq_empty !== 1'b1 || mem_wvalid !== 1'b0 || rou_sq_ready !== 1'b1 || ld_conflict !== 1'b0 || ld_hit !== 1'b0) begin
      n_fail++; $display("FAIL mid_stray: empty=%b wvalid=%b ready=%b conf=%b hit=%b want 1 0 1 0 0", sq_empty, mem_wvalid, rou_sq_ready, ld_conflict, ld_hit);
    end
    ld_valid = 0;
    commit(32'h500, 32'h77, 32'h50, 2'd2);
    step();
    n_tests++;
    if (mem_wvalid !== 1'b1 || mem_waddr !== 32'h500 || mem_wdata !== 32'h77) begin
      n_fail++; $display("FAIL mid_after: wvalid=%b addr=%h data=%h want 1 500 77", mem_wvalid, mem_waddr, mem_wdata);
    end
    do_reset();
  endtask

  task automatic test_random();
    localparam int N = 40;
    int next = 0, drained = 0, phase = 0, dly = 0, stall = 0;
    logic [31:0] pa, pd, exp_d;
    logic [1:0]  psz, lsz;
    logic [2:0]  up;
    logic offer, is_st, acc, popnow, accepted, exp_hit, exp_conf;
    do_reset();
    pa = 32'h100 + $urandom_range(0, 15); pd = $urandom; psz = 2'($urandom_range(0, 3));
    for (int cyc = 0; cyc < 3000 && drained < N; cyc++) begin
      offer = (next < N) && ($urandom_range(0, 3) != 0);
      is_st = offer && ($urandom_range(0, 5) != 0);
      up = 3'($urandom_range(0, 7));
      rou_valid = offer; rou_store = is_st; rou_alu = {up, psz};
      rou_sq_waddr = pa; rou_sq_wdata = pd; rou_pc = 32'(next);
      acc = is_st && (mq.size() < SQ);
      lsz = 2'($urandom_range(0, 3));
      up = 3'($urandom_range(0, 7));
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_addr = 32'h100 + $urandom_range(0, 15); ld_alu = {up, lsz};
      popnow = 1'b0; mem_bvalid = 0; mem_wready = 0;
      if (phase == 2) begin
        if (dly == 0) begin mem_bvalid = 1; popnow = 1'b1; end
      end else begin
        mem_bvalid = ($urandom_range(0, 7) == 0);
        if (mem_wvalid) mem_wready = ($urandom_range(0, 2) != 0);
      end
      accepted = mem_wvalid && mem_wready;
      #1;
      n_tests++;
      if (rou_sq_ready !== (mq.size() < SQ)) begin
        n_fail++; $display("FAIL rnd_ready: ready=%b want %b cyc=%0d", rou_sq_ready, (mq.size() < SQ), cyc);
      end
      model_lookup(ld_valid, ld_addr, lsz, exp_hit, exp_conf, exp_d);
      n_tests++;
      if (ld_hit !== exp_hit || ld_conflict !== exp_conf || ld_data !== exp_d) begin
        n_fail++; $display("FAIL rnd_lookup: addr=%h sz=%0d hit=%b conf=%b data=%h want %b %b %h", ld_addr, lsz, ld_hit, ld_conflict, ld_data, exp_hit, exp_conf, exp_d);
      end
      if (phase == 2) begin
        n_tests++;
        if (mem_wvalid !== 1'b0) begin
          n_fail++; $display("FAIL rnd_outstanding: wvalid=%b want 0", mem_wvalid);
        end
      end else if (mem_wvalid) begin
        stall = 0;
        n_tests++;
        if (mq.size() == 0 || mem_waddr !== mq[0].waddr || mem_wstrb !== mq[0].strb || mem_wpc !== mq[0].pc ||
            (mem_wdata & bmask(mq[0].strb)) !== (mq[0].wdata & bmask(mq[0].strb))) begin
          n_fail++; $display("FAIL rnd_write: addr=%h strb=%b data=%h pc=%h", mem_waddr, mem_wstrb, mem_wdata, mem_wpc);
        end
      end else if (mq.size() > 0) begin
        stall++;
        if (stall > 3) begin
          n_tests++; n_fail++; stall = 0;
          $display("FAIL rnd_nowrite: wvalid=0 with %0d entries, want 1", mq.size());
        end
      end
      step();
      if (acc) begin
        mq.push_back(mk_ent(pa, pd, 32'(next), psz));
        next++;
        pa = 32'h100 + $urandom_range(0, 15); pd = $urandom; psz = 2'($urandom_range(0, 3));
      end
      if (popnow) begin void'(mq.pop_front()); drained++; phase = 0; end
      else if (phase == 2) dly--;
      if (accepted) begin phase = 2; dly = $urandom_range(0, 3); end
    end
    idle_inputs();
    n_tests++;
    if (drained != N) begin
      n_fail++; $display("FAIL rnd_drained: got %0d want %0d", drained, N);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_basic_drain();
    test_byte_lane();
    test_full_wrap();
    test_forward();
    test_hold_stall();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
